// File: rtl/maze_pkg.sv
// Shared definitions for the maze walker datapath: direction codes,
// walker state enum and location packing helpers for the default geometry.
package maze_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    REPLAY   = 2'd1,
    FINISHED = 2'd2
  } state_e;

  localparam int unsigned COORD_W_DEF = 4;
  localparam int unsigned LOC_W_DEF   = 2 * COORD_W_DEF;

  typedef logic [COORD_W_DEF-1:0] coord_t;
  typedef logic [LOC_W_DEF-1:0]   loc_t;

  // Locations are packed {X,Y} with X in the upper half.
  function automatic loc_t mk_loc(input coord_t x, input coord_t y);
    return {x, y};
  endfunction

  function automatic coord_t loc_x(input loc_t l);
    return l[LOC_W_DEF-1:COORD_W_DEF];
  endfunction

  function automatic coord_t loc_y(input loc_t l);
    return l[COORD_W_DEF-1:0];
  endfunction

endpackage

// File: rtl/maze_walker_dp_path_lifo.sv
// Path LIFO: stores visited locations during search, pops for backtracking,
// then replays the stored entries bottom-to-top as a move stream.
module path_lifo
  import maze_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         done,
  input  logic         run,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] top_data,
  output state_e       state,
  output logic         empty,
  output logic         full,
  output logic         ovf_err,
  output logic         move_vld,
  output logic [W-1:0] move,
  output logic         replay_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] SP_FULL = DEPTH[AW:0];
  localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  sp_q;
  logic [AW:0]  sp_m1;
  logic [AW:0]  rd_q;
  state_e       state_q;
  logic         ovf_q;
  logic         vld_q;
  logic [W-1:0] move_q;
  logic         wr_en;

  // Status flags, stack top read port and the write qualifier.
  always_comb begin
    empty    = (sp_q == '0);
    full     = (sp_q == SP_FULL);
    sp_m1    = sp_q - SP_ONE;
    top_data = mem_q[sp_m1[AW-1:0]];
    // A simultaneous pop takes precedence, so the push is dropped.
    wr_en    = !rst && (state_q == SEARCH) && push && !pop && !full;
  end

  // Stack RAM write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[sp_q[AW-1:0]] <= wr_data;
  end

  // Search / replay / finished sequencing with pointer, error and move registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      sp_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      move_q  <= '0;
    end else begin
      case (state_q)
        SEARCH: begin
          vld_q <= 1'b0;
          if (pop) begin
            if (!empty) sp_q <= sp_m1;
            else        ovf_q <= 1'b1;
          end else if (push) begin
            if (!full) sp_q <= sp_q + SP_ONE;
            else       ovf_q <= 1'b1;
          end
          if (done) begin
            state_q <= REPLAY;
            rd_q    <= '0;
          end
        end
        REPLAY: begin
          if (rd_q == sp_q) begin
            state_q <= FINISHED;
            vld_q   <= 1'b0;
          end else if (run) begin
            move_q <= mem_q[rd_q[AW-1:0]];
            vld_q  <= 1'b1;
            rd_q   <= rd_q + SP_ONE;
          end else begin
            vld_q <= 1'b0;
          end
        end
        FINISHED: begin
          vld_q <= 1'b0;
        end
        default: begin
          state_q <= SEARCH;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign ovf_err     = ovf_q;
  assign move_vld    = vld_q;
  assign move        = move_q;
  assign replay_done = (state_q == FINISHED);

endmodule

// File: rtl/maze_walker_dp.sv
// Maze walker datapath: current location register, one-step neighbour
// arithmetic with edge detection, and the path LIFO for backtrack/replay.
module maze_walker_dp
  import maze_pkg::*;
#(
  parameter int unsigned COORD_W   = 4,
  parameter int unsigned STK_DEPTH = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ld,
  input  logic                   step,
  input  logic [1:0]             dir,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   done,
  input  logic                   run,
  output logic [2*COORD_W-1:0]   nxt_loc,
  output logic [2*COORD_W-1:0]   cur_loc,
  output logic                   edge_hit,
  output logic                   stk_empty,
  output logic                   stk_full,
  output logic                   ovf_err,
  output logic                   move_vld,
  output logic [2*COORD_W-1:0]   move,
  output logic                   replay_done
);

  localparam int unsigned LOC_W = 2 * COORD_W;
  localparam logic [COORD_W-1:0] C_ONE = {{(COORD_W-1){1'b0}}, 1'b1};

  logic [LOC_W-1:0]   cur_loc_q;
  logic [LOC_W-1:0]   cur_loc_d;
  logic [LOC_W-1:0]   step_loc;
  logic [LOC_W-1:0]   top_loc;
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic [COORD_W-1:0] operand;
  logic [COORD_W-1:0] stepped;
  logic [COORD_W-1:0] edge_probe;
  logic               sel_x;
  state_e             state;

  // Neighbour arithmetic, edge detection and next-location priority mux.
  always_comb begin
    cur_x      = cur_loc_q[LOC_W-1:COORD_W];
    cur_y      = cur_loc_q[COORD_W-1:0];
    sel_x      = ^dir;
    operand    = sel_x ? cur_x : cur_y;
    stepped    = dir[0] ? (operand + C_ONE) : (operand - C_ONE);
    edge_probe = operand + {{(COORD_W-1){1'b0}}, dir[0]};
    edge_hit   = (edge_probe == '0);
    step_loc   = sel_x ? {stepped, cur_y} : {cur_x, stepped};
    if (rst)                    nxt_loc = '0;
    else if (pop && !stk_empty) nxt_loc = top_loc;
    else if (step)              nxt_loc = step_loc;
    else                        nxt_loc = cur_loc_q;
    cur_loc_d = (ld && (state == SEARCH)) ? nxt_loc : cur_loc_q;
  end

  // Current location register, frozen outside search.
  always_ff @(posedge clk) begin
    if (rst) cur_loc_q <= '0;
    else     cur_loc_q <= cur_loc_d;
  end

  assign cur_loc = cur_loc_q;

  path_lifo #(
    .W     (LOC_W),
    .DEPTH (STK_DEPTH)
  ) u_lifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pop         (pop),
    .done        (done),
    .run         (run),
    .wr_data     (cur_loc_q),
    .top_data    (top_loc),
    .state       (state),
    .empty       (stk_empty),
    .full        (stk_full),
    .ovf_err     (ovf_err),
    .move_vld    (move_vld),
    .move        (move),
    .replay_done (replay_done)
  );

endmodule

// File: tb/tb_maze_walker_dp.sv
// Scoreboard bench for maze_walker_dp (COORD_W=4, STK_DEPTH=4): a queue-based
// reference model predicts each cycle's outputs and the replayed move stream.
module tb_maze_walker_dp;

  localparam int N     = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, ld = 1'b0, step = 1'b0, push = 1'b0, pop = 1'b0;
  logic       done = 1'b0, run = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [7:0] nxt_loc, cur_loc, move;
  logic       edge_hit, stk_empty, stk_full, ovf_err, move_vld, replay_done;

  maze_walker_dp #(.COORD_W(4), .STK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ld(ld), .step(step), .dir(dir), .push(push),
    .pop(pop), .done(done), .run(run), .nxt_loc(nxt_loc), .cur_loc(cur_loc),
    .edge_hit(edge_hit), .stk_empty(stk_empty), .stk_full(stk_full),
    .ovf_err(ovf_err), .move_vld(move_vld), .move(move),
    .replay_done(replay_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] nxt;
    logic       eh;
    logic [7:0] cur;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       vld;
    logic       rdone;
    logic [7:0] mv;
  } snap_t;

  snap_t      exp_q[$];
  logic [7:0] mv_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state: coordinates, stack as a queue, phase 0/1/2.
  int cx, cy, mode, rd, mv;
  int stk[$];
  bit m_ovf, mvld;

  function automatic logic [7:0] mk(input int x, input int y);
    return 8'(x * N + y);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(cur_loc) $display("cur_loc X=%0d Y=%0d", cur_loc[7:4], cur_loc[3:0]);

  // Monitor: one expected snapshot per cycle, plus the move stream.
  always @(negedge clk) begin
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("nxt_loc", 32'(nxt_loc), 32'(s.nxt));
      chk("edge_hit", 32'(edge_hit), 32'(s.eh));
      chk("cur_loc", 32'(cur_loc), 32'(s.cur));
      chk("stk_empty", 32'(stk_empty), 32'(s.empty));
      chk("stk_full", 32'(stk_full), 32'(s.full));
      chk("ovf_err", 32'(ovf_err), 32'(s.ovf));
      chk("move_vld", 32'(move_vld), 32'(s.vld));
      chk("replay_done", 32'(replay_done), 32'(s.rdone));
      chk("move_hold", 32'(move), 32'(s.mv));
    end
    if (move_vld === 1'b1) begin
      if (mv_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL move_unexpected: got %h expected none at %0t", move, $time);
      end else begin
        chk("move_stream", 32'(move), 32'(mv_q.pop_front()));
      end
    end
  end

  function automatic void model_reset();
    cx = 0; cy = 0; mode = 0; rd = 0; mv = 0;
    stk.delete();
    m_ovf = 0; mvld = 0;
  endfunction

  // Drive one cycle, predict its outputs, advance the model across the edge.
  task automatic cyc(input logic i_rst, input logic i_ld, input logic i_step,
                     input logic [1:0] i_dir, input logic i_push, input logic i_pop,
                     input logic i_done, input logic i_run);
    snap_t s;
    int    opnd, stp, old;
    bit    selx;
    logic [7:0] nloc;
    rst = i_rst; ld = i_ld; step = i_step; dir = i_dir;
    push = i_push; pop = i_pop; done = i_done; run = i_run;
    selx = i_dir[1] ^ i_dir[0];
    opnd = selx ? cx : cy;
    stp  = i_dir[0] ? (opnd + 1) % N : (opnd + N - 1) % N;
    if (i_rst)                         nloc = 8'h00;
    else if (i_pop && stk.size() > 0)  nloc = 8'(stk[$]);
    else if (i_step)                   nloc = selx ? mk(stp, cy) : mk(cx, stp);
    else                               nloc = mk(cx, cy);
    s.nxt   = nloc;
    s.eh    = ((opnd + int'(i_dir[0])) % N) == 0;
    s.cur   = mk(cx, cy);
    s.empty = (stk.size() == 0);
    s.full  = (stk.size() == DEPTH);
    s.ovf   = m_ovf;
    s.vld   = mvld;
    s.rdone = (mode == 2);
    s.mv    = 8'(mv);
    exp_q.push_back(s);
    if (i_rst) begin
      model_reset();
    end else if (mode == 0) begin
      old = int'(mk(cx, cy));
      if (i_pop) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_ovf = 1;
      end else if (i_push) begin
        if (stk.size() < DEPTH) stk.push_back(old);
        else m_ovf = 1;
      end
      if (i_ld) begin
        cx = int'(nloc) / N;
        cy = int'(nloc) % N;
      end
      if (i_done) begin
        mode = 1;
        rd = 0;
      end
      mvld = 0;
    end else if (mode == 1) begin
      if (rd == stk.size()) begin
        mode = 2;
        mvld = 0;
      end else if (i_run) begin
        mv = stk[rd];
        mv_q.push_back(8'(mv));
        mvld = 1;
        rd++;
      end else begin
        mvld = 0;
      end
    end else begin
      mvld = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  task automatic do_rst();
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  // Walk the model (and DUT) to (x,y) with committed single steps.
  task automatic goto_xy(input int x, input int y);
    while (cx != x) cyc(0, 1, 1, (cx < x) ? 2'b01 : 2'b10, 0, 0, 0, 0);
    while (cy != y) cyc(0, 1, 1, (cy < y) ? 2'b11 : 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_rst();

    // Step arithmetic from 0x55 for all four directions, then edge cases.
    goto_xy(5, 5);
    for (int d = 0; d < 4; d++) cyc(0, 0, 1, 2'(d), 0, 0, 0, 0);
    cyc(0, 1, 1, 2'b01, 0, 0, 0, 0);
    do_rst();
    cyc(0, 0, 1, 2'b00, 0, 0, 0, 0);
    goto_xy(15, 5);
    cyc(0, 0, 1, 2'b01, 0, 0, 0, 0);
    cyc(0, 0, 1, 2'b10, 0, 0, 0, 0);

    // Backtrack.
    do_rst();
    goto_xy(1, 1);
    cyc(0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc(0, 1, 1, 2'b11, 0, 0, 0, 0);
    cyc(0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc(0, 1, 1, 2'b11, 0, 0, 0, 0);
    cyc(0, 1, 0, 2'b00, 0, 1, 0, 0);
    cyc(0, 1, 0, 2'b00, 0, 1, 0, 0);
    idle(1);

    // Errors: pop when empty, then overfill.
    do_rst();
    cyc(0, 1, 0, 2'b00, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 2'b11, 1, 0, 0, 0);
    idle(1);

    // Simultaneous push and pop: pop only.
    do_rst();
    cyc(0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc(0, 1, 1, 2'b01, 0, 0, 0, 0);
    cyc(0, 1, 0, 2'b00, 1, 1, 0, 0);
    idle(1);

    // Replay of 0x00, 0x01, 0x11.
    do_rst();
    cyc(0, 0, 0, 2'b00, 1, 0, 0, 0);
    goto_xy(0, 1);
    cyc(0, 0, 0, 2'b00, 1, 0, 0, 0);
    goto_xy(1, 1);
    cyc(0, 0, 0, 2'b00, 1, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 1, 2'b01, 1, 0, 1, 1);

    // Done with an empty stack.
    do_rst();
    cyc(0, 0, 0, 2'b00, 0, 0, 1, 0);
    idle(3);

    // Reset in the middle of a replay.
    do_rst();
    cyc(0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc(0, 1, 1, 2'b11, 1, 0, 0, 0);
    cyc(0, 0, 0, 2'b00, 0, 0, 1, 0);
    cyc(0, 0, 0, 2'b00, 0, 0, 0, 1);
    do_rst();
    idle(2);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      logic r_rst;
      r_rst = ($urandom_range(0, 199) == 0) || (mode == 2 && $urandom_range(0, 3) == 0);
      cyc(r_rst, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
          2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0,
          (mode == 0) ? ($urandom_range(0, 59) == 0) : 1'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0);
    end

    idle(2);
    @(negedge clk);
    #1;
    chk("move_drain", 32'(mv_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_walker_dp.md
Name: maze_walker_dp

Overview:
- Parametrised datapath for the maze-solving rat.
- Holds the current {X,Y} location, computes the one-step neighbour for a 2-bit direction, and flags out-of-range steps.
- Keeps a depth-configurable LIFO of visited locations for backtracking.
- After the search ends, replays the stored path bottom-to-top as a move stream. Driven by the maze controller FSM; results go to the testbench/display.

Parameters:
- COORD_W, 4, bits per coordinate. Location width LOC_W = 2*COORD_W, packed {X,Y}.
- STK_DEPTH, 256, LIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld  in  1  commit nxt_loc into cur_loc this edge
- step  in  1  select stepped location as nxt_loc
- dir  in  2  00 Y-1, 11 Y+1, 01 X+1, 10 X-1
- push  in  1  push cur_loc onto LIFO
- pop  in  1  pop LIFO top; top becomes nxt_loc
- done  in  1  pulse: search finished, enter replay
- run  in  1  replay advance request
- nxt_loc  out  LOC_W  combinational next location
- cur_loc  out  LOC_W  registered current location
- edge_hit  out  1  selected step would wrap (out of maze)
- stk_empty  out  1  LIFO empty
- stk_full  out  1  LIFO full
- ovf_err  out  1  sticky: push when full, or pop when empty
- move_vld  out  1  move valid (replay)
- move  out  LOC_W  replayed location
- replay_done  out  1  all stored entries emitted

Behaviour:
- Reset, synchronous: cur_loc=0, sp=0, rd_ptr=0, state=SEARCH, ovf_err=0, move_vld=0, move=0, replay_done=0. The stack RAM is not cleared.
- Axis select: sel_x = ^dir. Operand = sel_x ? X : Y. Stepped operand = operand + 1 if dir[0], else operand - 1, modulo 2^COORD_W. The other coordinate is unchanged.
- edge_hit = ((operand + dir[0]) mod 2^COORD_W) == 0. This is true for a decrement from 0 or an increment from all-ones. It is combinational and valid every cycle.
- nxt_loc priority: rst gives 0, then pop with !stk_empty gives the stack top, then step gives the stepped location, otherwise cur_loc.
- cur_loc <= nxt_loc on the edge when ld=1 and state=SEARCH; otherwise it holds.
- States: SEARCH, REPLAY, FINISHED.
- SEARCH:
  - push with !stk_full writes cur_loc (the pre-edge value) at sp, then sp++.
  - pop with !stk_empty: sp--.
  - push and pop in the same cycle: pop wins, push is dropped, no error.
  - push when full, or pop when empty: no state change, ovf_err <= 1 (sticky until rst).
  - done=1 moves to REPLAY at the next edge, with rd_ptr <= 0. An in-flight push or pop on that edge is still applied first.
- REPLAY:
  - push, pop, ld and step are ignored; cur_loc is frozen.
  - Each cycle with run=1 and rd_ptr<sp: move <= stack[rd_ptr], move_vld <= 1, rd_ptr++. One-cycle latency from run to move_vld.
  - run=0: move_vld <= 0 and move holds.
  - When rd_ptr reaches sp, go to FINISHED.
  - If sp=0 on entry, go to FINISHED next cycle with no moves.
- FINISHED: replay_done=1, move_vld=0. Only rst leaves this state; done is ignored.
- stk_empty = (sp==0). stk_full = (sp==STK_DEPTH). sp is $clog2(STK_DEPTH)+1 bits.
- Display: on every cur_loc change, print the decimal X and Y, sim-only.
- rst mid-replay: everything returns to reset values on the next edge.

Decomposition:
- Shared package maze_pkg holds:
  - dir encodings DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_LEFT=2'b10, DIR_DOWN=2'b11;
  - state enum {SEARCH, REPLAY, FINISHED};
  - the loc_t packing helpers.
- One sub-module, path_lifo, owns the RAM, sp, rd_ptr, full/empty, error and the replay read port. Step arithmetic and the location register stay in the top.

Test Plan:
- Step arithmetic (COORD_W=4): from cur_loc=0x55 with ld=1 and step=1, dir 00/11/01/10 gives nxt_loc 0x54/0x56/0x65/0x45. From 0x00, dir=00 gives edge_hit=1; from 0xF5, dir=01 gives edge_hit=1.
- Backtrack: push at 0x11, step to 0x12, push, step to 0x13, then pop+ld gives cur_loc=0x12 and sp=1. A second pop gives 0x11 and stk_empty=1.
- Error: a pop when empty gives ovf_err=1 with cur_loc unchanged. Fill STK_DEPTH=4 with 4 pushes, then a 5th push gives ovf_err=1 and sp=4.
- Replay: push 0x00, 0x01, 0x11, then done, then run held high. move_vld is seen on 3 consecutive cycles with move 0x00, 0x01, 0x11, then replay_done=1.
- Edge cases:
  - done with an empty stack reaches replay_done after 1 cycle with no move_vld.
  - Simultaneous push and pop gives a pop-only result.
  - rst mid-replay clears move_vld, replay_done and sp.
